// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: FSM states, Funct3 encodings, access sizes
// and the low-address helpers used by the alignment logic.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Funct3[1:0] is the access size for both loads and stores
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  function automatic logic [1:0] align_off(input logic [1:0] off, input logic [1:0] size);
    case (size)
      SZ_B:    align_off = off;
      SZ_H:    align_off = {off[1], 1'b0};
      default: align_off = 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] off, input logic [1:0] size);
    case (size)
      SZ_B:    is_misaligned = 1'b0;
      SZ_H:    is_misaligned = off[0];
      default: is_misaligned = |off;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane logic: store replication + byte enables, load lane select + extension.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  st_off_i,
  input  logic [1:0]  st_size_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] st_data_o,
  output logic [3:0]  st_be_o,
  input  logic [1:0]  ld_off_i,
  input  logic [2:0]  ld_funct3_i,
  input  logic [31:0] ld_data_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] ld_sh;

  always_comb begin
    st_data_o = st_data_i;
    st_be_o   = 4'hF;
    case (st_size_i)
      SZ_B: begin
        st_data_o = {4{st_data_i[7:0]}};
        st_be_o   = 4'b0001 << st_off_i;
      end
      SZ_H: begin
        st_data_o = {2{st_data_i[15:0]}};
        st_be_o   = 4'b0011 << st_off_i;
      end
      default: ;
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend by Funct3
  assign ld_sh = ld_data_i >> {ld_off_i, 3'b000};

  always_comb begin
    ld_data_o = ld_sh;
    case (ld_funct3_i)
      F3_LB:   ld_data_o = {{24{ld_sh[7]}}, ld_sh[7:0]};
      F3_LH:   ld_data_o = {{16{ld_sh[15]}}, ld_sh[15:0]};
      F3_LBU:  ld_data_o = {24'h0, ld_sh[7:0]};
      F3_LHU:  ld_data_o = {16'h0, ld_sh[15:0]};
      default: ld_data_o = ld_sh;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding data-memory access with stall and lane alignment.
// Define LSU_MISALIGN_CHECK_EN to fault misaligned half/word accesses instead of aligning them.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        Funct3,
  input  logic [ADDR_W-1:0] ALUResult,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  output logic              Stall,
  output logic              Fault,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_be,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);

  lsu_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        f3_q;
  logic              we_q;
  logic [31:0]       wdata_q, rdata_q;
  logic [3:0]        be_q;

  logic        req, misalign;
  logic [1:0]  off_d;
  logic [31:0] lane_wdata, ld_ext;
  logic [3:0]  lane_be;

  assign req = MemRead | MemWrite;

`ifdef LSU_MISALIGN_CHECK_EN
  logic fault_q;
  assign misalign = is_misaligned(ALUResult[1:0], Funct3[1:0]);
  assign off_d    = ALUResult[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= (state_q == ST_IDLE) && req && misalign;
  end
  assign Fault = fault_q;
`else
  assign misalign = 1'b0;
  assign off_d    = align_off(ALUResult[1:0], Funct3[1:0]);
  assign Fault    = 1'b0;
`endif

  lsu_align u_align (
    .st_off_i    (off_d),
    .st_size_i   (Funct3[1:0]),
    .st_data_i   (WriteData),
    .st_data_o   (lane_wdata),
    .st_be_o     (lane_be),
    .ld_off_i    (addr_q[1:0]),
    .ld_funct3_i (f3_q),
    .ld_data_i   (bus_rdata),
    .ld_data_o   (ld_ext)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req && !misalign) begin
            addr_q  <= {ALUResult[ADDR_W-1:2], off_d};
            f3_q    <= Funct3;
            we_q    <= MemWrite;
            wdata_q <= lane_wdata;
            be_q    <= MemWrite ? lane_be : 4'hF;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (bus_ack) begin
            if (!we_q) rdata_q <= ld_ext;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Gate with reset so an abandoned access releases the bus and pipeline immediately
  assign bus_req   = !reset && (state_q == ST_BUSY);
  assign Stall     = !reset && ((state_q == ST_BUSY) ||
                                ((state_q == ST_IDLE) && req && !misalign));
  assign bus_we    = we_q;
  assign bus_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus_wdata = wdata_q;
  assign bus_be    = be_q;
  assign ReadData  = rdata_q;

endmodule
